// File: rtl/game_core.sv
// Gameplay engine: game state, farmer lane, one falling object, score and lives.
// Define GAME_SPEEDUP_EN to double the fall rate once the score reaches SPEED_THRESH.
module game_core #(
    parameter int LANES        = 8,
    parameter int ROWS         = 12,
    parameter int LIVES        = 3,
    parameter int SCORE_MAX    = 99
`ifdef GAME_SPEEDUP_EN
    ,
    parameter int SPEED_THRESH = 50
`endif
) (
    input  logic       clk_2,
    input  logic       _rst,
    input  logic       start,
    input  logic       key_valid,
    input  logic       key_pressed,
    input  logic [3:0] key_num,
    input  logic       step_tick,
    output logic [1:0] state,
    output logic [2:0] farmer_pos,
    output logic       obj_valid,
    output logic [2:0] obj_lane,
    output logic [3:0] obj_row,
    output logic [1:0] obj_kind,
    output logic [6:0] score,
    output logic [1:0] lives,
    output logic       catch_pulse,
    output logic       miss_pulse
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_GAME = 2'b10,
        S_OVER = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] farmer_q, farmer_d;
    logic       obj_valid_q, obj_valid_d;
    logic [2:0] obj_lane_q, obj_lane_d;
    logic [3:0] obj_row_q, obj_row_d;
    logic [1:0] obj_kind_q, obj_kind_d;
    logic [6:0] score_q, score_d;
    logic [1:0] lives_q, lives_d;
    logic       catch_q, catch_d;
    logic       miss_q, miss_d;
    logic [7:0] lfsr_q, lfsr_d;

    logic       spawn;
    logic       lose;
    logic [3:0] row_next;
    logic [7:0] score_sum;
    logic [2:0] spawn_lane;

    always_ff @(posedge clk_2 or posedge _rst) begin
        if (_rst) begin
            state_q     <= S_IDLE;
            farmer_q    <= 3'd3;
            obj_valid_q <= 1'b0;
            obj_lane_q  <= '0;
            obj_row_q   <= '0;
            obj_kind_q  <= '0;
            score_q     <= '0;
            lives_q     <= 2'(LIVES);
            catch_q     <= 1'b0;
            miss_q      <= 1'b0;
            lfsr_q      <= 8'hA5;
        end else begin
            state_q     <= state_d;
            farmer_q    <= farmer_d;
            obj_valid_q <= obj_valid_d;
            obj_lane_q  <= obj_lane_d;
            obj_row_q   <= obj_row_d;
            obj_kind_q  <= obj_kind_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            catch_q     <= catch_d;
            miss_q      <= miss_d;
            lfsr_q      <= lfsr_d;
        end
    end

    always_comb begin
        spawn_lane = 3'(32'(lfsr_q[2:0]) % LANES);
        score_sum  = {1'b0, score_q} + {6'b0, obj_kind_q} + 8'd1;
`ifdef GAME_SPEEDUP_EN
        if ({1'b0, score_q} >= 8'(SPEED_THRESH))
            row_next = (obj_row_q >= 4'(ROWS - 3)) ? 4'(ROWS - 1) : obj_row_q + 4'd2;
        else
            row_next = obj_row_q + 4'd1;
`else
        row_next = obj_row_q + 4'd1;
`endif
    end

    always_comb begin
        state_d     = state_q;
        farmer_d    = farmer_q;
        obj_valid_d = obj_valid_q;
        obj_lane_d  = obj_lane_q;
        obj_row_d   = obj_row_q;
        obj_kind_d  = obj_kind_q;
        score_d     = score_q;
        lives_d     = lives_q;
        catch_d     = 1'b0;
        miss_d      = 1'b0;
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        spawn       = 1'b0;
        lose        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_GAME;
                    score_d  = '0;
                    lives_d  = 2'(LIVES);
                    farmer_d = 3'd3;
                    spawn    = 1'b1;
                end
            end
            S_GAME: begin
                if (key_valid && key_pressed) begin
                    if (key_num == 4'd2 && farmer_q != '0)
                        farmer_d = farmer_q - 3'd1;
                    else if (key_num == 4'd3 && farmer_q != 3'(LANES - 1))
                        farmer_d = farmer_q + 3'd1;
                end
                if (step_tick) begin
                    if (obj_row_q == 4'(ROWS - 1)) begin
                        // Landing compares against farmer_q, so a same-cycle move does not affect it.
                        spawn = 1'b1;
                        if (obj_lane_q == farmer_q) begin
                            catch_d = 1'b1;
                            if (obj_kind_q == 2'd3)
                                lose = 1'b1;
                            else if (score_sum > 8'(SCORE_MAX))
                                score_d = 7'(SCORE_MAX);
                            else
                                score_d = score_sum[6:0];
                        end else if (obj_kind_q != 2'd3) begin
                            miss_d = 1'b1;
                            lose   = 1'b1;
                        end
                        if (lose) begin
                            lives_d = lives_q - 2'd1;
                            if (lives_q == 2'd1) begin
                                state_d     = S_OVER;
                                obj_valid_d = 1'b0;
                                spawn       = 1'b0;
                            end
                        end
                    end else begin
                        obj_row_d = row_next;
                    end
                end
            end
            S_OVER: begin
                if (start)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (spawn) begin
            obj_lane_d  = spawn_lane;
            obj_kind_d  = lfsr_q[4:3];
            obj_row_d   = '0;
            obj_valid_d = 1'b1;
        end
    end

    assign state       = state_q;
    assign farmer_pos  = farmer_q;
    assign obj_valid   = obj_valid_q;
    assign obj_lane    = obj_lane_q;
    assign obj_row     = obj_row_q;
    assign obj_kind    = obj_kind_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign catch_pulse = catch_q;
    assign miss_pulse  = miss_q;

endmodule

// File: tb/tb_game_core.sv
// Scoreboarded bench for game_core: landing events are queued when issued and
// checked by a monitor whenever catch_pulse or miss_pulse is seen.
module tb_game_core;

    localparam int LANES     = 8;
    localparam int ROWS      = 12;
    localparam int LIVES     = 3;
    localparam int SCORE_MAX = 99;
    localparam int SPEED_THRESH = 50;

    logic       clk_2 = 1'b0;
    logic       _rst = 1'b1;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_pressed = 1'b0;
    logic [3:0] key_num = 4'd0;
    logic       step_tick = 1'b0;
    logic [1:0] state;
    logic [2:0] farmer_pos;
    logic       obj_valid;
    logic [2:0] obj_lane;
    logic [3:0] obj_row;
    logic [1:0] obj_kind;
    logic [6:0] score;
    logic [1:0] lives;
    logic       catch_pulse;
    logic       miss_pulse;

    always #5 clk_2 = ~clk_2;

    game_core #(
        .LANES(LANES),
        .ROWS(ROWS),
        .LIVES(LIVES),
        .SCORE_MAX(SCORE_MAX)
    ) dut (
        .clk_2(clk_2),
        ._rst(_rst),
        .start(start),
        .key_valid(key_valid),
        .key_pressed(key_pressed),
        .key_num(key_num),
        .step_tick(step_tick),
        .state(state),
        .farmer_pos(farmer_pos),
        .obj_valid(obj_valid),
        .obj_lane(obj_lane),
        .obj_row(obj_row),
        .obj_kind(obj_kind),
        .score(score),
        .lives(lives),
        .catch_pulse(catch_pulse),
        .miss_pulse(miss_pulse)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded A5, steps every cycle.
    logic [7:0] m_lfsr;
    always @(posedge clk_2 or posedge _rst) begin
        if (_rst) m_lfsr <= 8'hA5;
        else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    typedef struct {
        bit is_catch;
        int sc;
        int lv;
    } ev_t;
    ev_t sb_q[$];
    ev_t mon_e;

    always @(negedge clk_2) begin
        if (!_rst && (catch_pulse || miss_pulse)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got catch=%0d miss=%0d expected none", catch_pulse, miss_pulse);
            end else begin
                mon_e = sb_q.pop_front();
                chk("ev_catch", catch_pulse, mon_e.is_catch);
                chk("ev_miss", miss_pulse, !mon_e.is_catch);
                chk("ev_score", score, mon_e.sc);
                chk("ev_lives", lives, mon_e.lv);
            end
        end
    end

    int e_state, e_farmer, e_score, e_lives, e_lane, e_kind, e_row, e_valid;
    logic [7:0] cap_lfsr;

    task automatic model_reset();
        e_state = 0; e_farmer = 3; e_score = 0; e_lives = LIVES;
        e_lane = 0; e_kind = 0; e_row = 0; e_valid = 0;
    endtask

    task automatic spawn_model();
        e_lane  = int'(cap_lfsr[2:0]) % LANES;
        e_kind  = int'(cap_lfsr[4:3]);
        e_row   = 0;
        e_valid = 1;
    endtask

    function automatic int mv(input int f, input int kn);
        if (kn == 2 && f > 0) return f - 1;
        if (kn == 3 && f < LANES - 1) return f + 1;
        return f;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_state"}, state, e_state);
        chk({tag, "_farmer"}, farmer_pos, e_farmer);
        chk({tag, "_valid"}, obj_valid, e_valid);
        chk({tag, "_lane"}, obj_lane, e_lane);
        chk({tag, "_row"}, obj_row, e_row);
        chk({tag, "_kind"}, obj_kind, e_kind);
        chk({tag, "_score"}, score, e_score);
        chk({tag, "_lives"}, lives, e_lives);
    endtask

    // One clock cycle with the given inputs held across the active edge.
    task automatic cyc(input logic st, input logic tk, input logic kv, input logic kp, input logic [3:0] kn);
        @(negedge clk_2);
        start = st; step_tick = tk; key_valid = kv; key_pressed = kp; key_num = kn;
        cap_lfsr = m_lfsr;
        @(posedge clk_2);
        #1;
        start = 1'b0; step_tick = 1'b0; key_valid = 1'b0; key_pressed = 1'b0; key_num = 4'd0;
    endtask

    task automatic key_ev(input int kn, input bit pressed);
        cyc(1'b0, 1'b0, 1'b1, pressed, 4'(kn));
        if (e_state == 2 && pressed) e_farmer = mv(e_farmer, kn);
    endtask

    task automatic start_pulse();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        if (e_state == 0) begin
            e_state = 2; e_score = 0; e_lives = LIVES; e_farmer = 3;
            spawn_model();
        end else if (e_state == 3) begin
            e_state = 0;
        end
    endtask

    task automatic tick_row();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        if (e_state == 2) begin
`ifdef GAME_SPEEDUP_EN
            if (e_score >= SPEED_THRESH) e_row = (e_row + 2 > ROWS - 1) ? ROWS - 1 : e_row + 2;
            else e_row = e_row + 1;
`else
            e_row = e_row + 1;
`endif
        end
    endtask

    // Steer to (or away from) the object, drop it to the landing row, then land it.
    task automatic play(input bit do_catch, input bit move_on_land);
        int target, land_kn, nsc;
        bit hit, bug, has_ev, is_c, lose;
        target = do_catch ? e_lane : (e_lane == 0 ? 1 : e_lane - 1);
        for (int n = 0; n < 16 && e_farmer != target; n++)
            key_ev(e_farmer < target ? 3 : 2, 1'b1);
        for (int n = 0; n < ROWS && e_row < ROWS - 1; n++)
            tick_row();
        chk("pre_land_row", obj_row, ROWS - 1);
        hit = (e_lane == e_farmer);
        bug = (e_kind == 3);
        has_ev = 0; is_c = 0; lose = 0;
        if (hit) begin
            has_ev = 1; is_c = 1;
            if (bug) lose = 1;
            else begin
                nsc = e_score + e_kind + 1;
                e_score = (nsc > SCORE_MAX) ? SCORE_MAX : nsc;
            end
        end else if (!bug) begin
            has_ev = 1; lose = 1;
        end
        if (lose) e_lives = e_lives - 1;
        if (has_ev) sb_q.push_back('{is_catch: is_c, sc: e_score, lv: e_lives});
        land_kn = move_on_land ? (e_farmer < LANES - 1 ? 3 : 2) : 0;
        cyc(1'b0, 1'b1, move_on_land, 1'b1, 4'(land_kn));
        if (move_on_land) e_farmer = mv(e_farmer, land_kn);
        if (lose && e_lives == 0) begin
            e_state = 3; e_valid = 0;
        end else begin
            spawn_model();
        end
        check_all("land");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sat, done;
        model_reset();
        repeat (3) @(posedge clk_2);
        #1;
        check_all("reset");
        chk("reset_catch", catch_pulse, 0);
        chk("reset_miss", miss_pulse, 0);
        @(negedge clk_2);
        _rst = 1'b0;

        // IDLE ignores keys and ticks
        key_ev(2, 1'b1);
        tick_row();
        check_all("idle");

        start_pulse();
        check_all("start");

        for (int i = 0; i < 4; i++) key_ev(2, 1'b1);
        chk("left4", farmer_pos, 0);
        key_ev(2, 1'b1);
        chk("left_clamp", farmer_pos, 0);
        for (int i = 0; i < 9; i++) key_ev(3, 1'b1);
        chk("right_clamp", farmer_pos, 7);
        key_ev(2, 1'b0);
        key_ev(4, 1'b1);
        check_all("break_inv");
        start_pulse();
        check_all("start_in_game");

        // First landing also moves the farmer in the same cycle
        play(e_kind != 3, 1'b1);

        sat = 0;
        for (int n = 0; n < 300 && !sat && e_state == 2; n++) begin
            if (e_kind == 3) play(1'b0, 1'b0);
            else begin
                if (e_score + e_kind + 1 > SCORE_MAX) sat = 1;
                play(1'b1, 1'b0);
            end
        end
        chk("saturated_seen", sat, 1);
        chk("score_sat", score, SCORE_MAX);

        done = 0;
        for (int n = 0; n < 50 && !done; n++) begin
            if (e_kind != 3) done = 1;
            play(1'b0, 1'b0);
        end
        chk("after_miss_lives", lives, 2);

        done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            if (e_kind == 3) done = 1;
            play(1'b1, 1'b0);
        end
        chk("after_bug_lives", lives, 1);

        done = 0;
        for (int n = 0; n < 50 && !done; n++) begin
            if (e_kind != 3) done = 1;
            play(1'b0, 1'b0);
        end
        chk("over_state", state, 2'b11);
        chk("over_valid", obj_valid, 0);

        key_ev(3, 1'b1);
        tick_row();
        check_all("over_hold");
        start_pulse();
        check_all("over_to_idle");
        start_pulse();
        check_all("restart");

        // Asynchronous reset mid-game, away from any clock edge
        tick_row();
        key_ev(2, 1'b1);
        @(negedge clk_2);
        #2;
        _rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk_2);
        _rst = 1'b0;

        repeat (3) @(negedge clk_2);
        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
